// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, requester IDs,
// ALU timing and the ALU opcode / enable codes used by the requesters.
package alu_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

    // Requester identification
    localparam int                  NUM_REQ  = 2;
    localparam int                  REQ_ID_W = 1;
    localparam logic [REQ_ID_W-1:0] REQ0     = 1'b0;
    localparam logic [REQ_ID_W-1:0] REQ1     = 1'b1;

    // Registered ALU: result appears one cycle after the op is sampled
    localparam int ALU_LAT = 1;

    // Generic switches
    localparam bit ENABLE  = 1'b1;
    localparam bit DISABLE = 1'b0;

    // ALU opcodes
    localparam logic [5:0] ALUOP_ADD = 6'h20;
    localparam logic [5:0] ALUOP_SUB = 6'h22;
    localparam logic [5:0] ALUOP_AND = 6'h24;
    localparam logic [5:0] ALUOP_OR  = 6'h25;
    localparam logic [5:0] ALUOP_XOR = 6'h26;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin when RR_EN is set, otherwise req0 always wins.
// The last winner is remembered only when a grant is actually taken.
module rr_arb2
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = ENABLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_elig,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    // Pick one winner among the eligible requesters
    always_comb begin
        o_grant = 2'b00;
        case (i_elig)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (RR_EN && (r_last_grant == REQ0)) ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Track the last accepted requester; starts at req1 so req0 wins first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last_grant <= REQ1;
        else if (i_accept)
            r_last_grant <= o_grant[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two valid/ready requesters. An accepted
// op is driven to the ALU for one cycle (EXEC), its result is captured in the
// following cycle (CAPT) into the owner's response buffer. A new op may be
// accepted in CAPT, giving one op every two cycles back-to-back.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter bit RR_EN  = ENABLE
) (
    input  logic              clk,
    input  logic              reset,
    // request channels
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    // response channels
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_ov,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_ov,
    // ALU interface
    output logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] alu_src0,
    output logic [DATA_W-1:0] alu_src1,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_ov,
    // status
    output logic              busy
);

    state_t                              r_state, w_state_nxt;
    logic [REQ_ID_W-1:0]                 r_owner;
    logic [OP_W-1:0]                     r_alu_control;
    logic [DATA_W-1:0]                   r_alu_src0, r_alu_src1;

    logic [NUM_REQ-1:0]                  r_rsp_valid, r_rsp_zero, r_rsp_ov;
    logic [NUM_REQ-1:0][DATA_W-1:0]      r_rsp_result;

    logic [NUM_REQ-1:0]                  w_req_valid, w_rsp_ready;
    logic [NUM_REQ-1:0][OP_W-1:0]        w_req_op;
    logic [NUM_REQ-1:0][DATA_W-1:0]      w_req_a, w_req_b;
    logic [NUM_REQ-1:0]                  w_outstanding, w_elig, w_grant;
    logic                                w_can_accept, w_accept, w_capture;
    logic [REQ_ID_W-1:0]                 w_sel;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};
    assign w_req_op    = {req1_op, req0_op};
    assign w_req_a     = {req1_a, req0_a};
    assign w_req_b     = {req1_b, req0_b};

    // Reset is folded in so no request is acknowledged while held in reset
    assign w_can_accept = reset && ((r_state == ST_IDLE) || (r_state == ST_CAPT));
    assign w_capture    = (r_state == ST_CAPT);

    // A requester is blocked while it owns the in-flight op or its buffer
    // still holds an unconsumed result; this keeps captures collision-free.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
        assign w_outstanding[g] = ((r_state != ST_IDLE) && (r_owner == REQ_ID_W'(g))) ||
                                  (r_rsp_valid[g] && !w_rsp_ready[g]);
        assign w_elig[g]        = w_req_valid[g] && !w_outstanding[g] && w_can_accept;
    end

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_elig   (w_elig),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_accept = |w_grant;
    assign w_sel    = w_grant[1];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state: EXEC always moves to CAPT, CAPT may chain into EXEC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_CAPT;
            ST_CAPT: w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU operands load only on accept and are held through CAPT so the
    // ALU's combinational overflow still matches the op being captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_control <= '0;
            r_alu_src0    <= '0;
            r_alu_src1    <= '0;
            r_owner       <= REQ0;
        end else if (w_accept) begin
            r_alu_control <= w_req_op[w_sel];
            r_alu_src0    <= w_req_a[w_sel];
            r_alu_src1    <= w_req_b[w_sel];
            r_owner       <= w_sel;
        end
    end

    // Per-requester response buffers: fill on capture, drain on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= '0;
            r_rsp_zero   <= '0;
            r_rsp_ov     <= '0;
            r_rsp_result <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_capture && (r_owner == REQ_ID_W'(i))) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_rsp_result[i] <= alu_result;
                    r_rsp_zero[i]   <= alu_zero;
                    r_rsp_ov[i]     <= alu_ov;
                end else if (r_rsp_valid[i] && w_rsp_ready[i]) begin
                    r_rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

    assign req0_ready  = w_grant[0];
    assign req1_ready  = w_grant[1];

    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp0_result = r_rsp_result[0];
    assign rsp0_zero   = r_rsp_zero[0];
    assign rsp0_ov     = r_rsp_ov[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp1_result = r_rsp_result[1];
    assign rsp1_zero   = r_rsp_zero[1];
    assign rsp1_ov     = r_rsp_ov[1];

    assign alu_control = r_alu_control;
    assign alu_src0    = r_alu_src0;
    assign alu_src1    = r_alu_src1;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter. Expected responses are pushed when a
// request is accepted and popped by a response monitor. A second instance
// with fixed priority shares the stimulus for grant-order comparison.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ov;
    } rsp_t;

    typedef struct {
        rsp_t r;
        int   cyc;
    } exp_t;

    localparam logic [5:0] OP_UNK = 6'h3F;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // shared stimulus
    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
    logic [5:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    rsp_t        e0, e1;

    // round-robin instance outputs
    logic        m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid;
    logic [31:0] m_rsp0_result, m_rsp1_result, m_alu_src0, m_alu_src1;
    logic        m_rsp0_zero, m_rsp1_zero, m_rsp0_ov, m_rsp1_ov, m_busy;
    logic [5:0]  m_alu_control;
    rsp_t        m_alu_q, m_alu_c;

    // fixed-priority instance outputs
    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp0_result, f_rsp1_result, f_alu_src0, f_alu_src1;
    logic        f_rsp0_zero, f_rsp1_zero, f_rsp0_ov, f_rsp1_ov, f_busy;
    logic [5:0]  f_alu_control;
    rsp_t        f_alu_q, f_alu_c;

    // Reference ALU behaviour (registered result/zero, combinational ov)
    function automatic rsp_t alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.res = '0;
        r.ov  = 1'b0;
        case (op)
            ALUOP_ADD: begin r.res = a + b; r.ov = (a[31] == b[31]) && (r.res[31] != a[31]); end
            ALUOP_SUB: begin r.res = a - b; r.ov = (a[31] != b[31]) && (r.res[31] != a[31]); end
            ALUOP_AND: r.res = a & b;
            ALUOP_OR:  r.res = a | b;
            ALUOP_XOR: r.res = a ^ b;
            default:   r.res = '0;
        endcase
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    always @(posedge clk) m_alu_q <= alu_f(m_alu_control, m_alu_src0, m_alu_src1);
    assign m_alu_c = alu_f(m_alu_control, m_alu_src0, m_alu_src1);
    always @(posedge clk) f_alu_q <= alu_f(f_alu_control, f_alu_src0, f_alu_src1);
    assign f_alu_c = alu_f(f_alu_control, f_alu_src0, f_alu_src1);

    alu_arbiter #(.DATA_W(32), .OP_W(6), .RR_EN(ENABLE)) u_m (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(m_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(m_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(m_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(m_rsp0_result), .rsp0_zero(m_rsp0_zero), .rsp0_ov(m_rsp0_ov),
        .rsp1_valid(m_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(m_rsp1_result), .rsp1_zero(m_rsp1_zero), .rsp1_ov(m_rsp1_ov),
        .alu_control(m_alu_control), .alu_src0(m_alu_src0), .alu_src1(m_alu_src1),
        .alu_result(m_alu_q.res), .alu_zero(m_alu_q.zero), .alu_ov(m_alu_c.ov),
        .busy(m_busy)
    );

    alu_arbiter #(.DATA_W(32), .OP_W(6), .RR_EN(DISABLE)) u_f (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(f_rsp0_result), .rsp0_zero(f_rsp0_zero), .rsp0_ov(f_rsp0_ov),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(f_rsp1_result), .rsp1_zero(f_rsp1_zero), .rsp1_ov(f_rsp1_ov),
        .alu_control(f_alu_control), .alu_src0(f_alu_src0), .alu_src1(f_alu_src1),
        .alu_result(f_alu_q.res), .alu_zero(f_alu_q.zero), .alu_ov(f_alu_c.ov),
        .busy(f_busy)
    );

    // ---------------- checking infrastructure ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic rsp_t mk(input logic [31:0] res, input logic z, input logic ov);
        rsp_t r;
        r.res = res; r.zero = z; r.ov = ov;
        return r;
    endfunction

    exp_t q[2][$];
    bit   seen[2];
    int   log_id[$], log_cyc[$], flog[$];

    logic [1:0]       rv, rr, rz, ro;
    logic [1:0][31:0] rres;
    assign rv   = {m_rsp1_valid, m_rsp0_valid};
    assign rr   = {rsp1_ready, rsp0_ready};
    assign rz   = {m_rsp1_zero, m_rsp0_zero};
    assign ro   = {m_rsp1_ov, m_rsp0_ov};
    assign rres = {m_rsp1_result, m_rsp0_result};

    // Issue side: every accepted request pushes its hand-computed response
    always @(negedge clk) begin
        if (reset) begin
            if (req0_valid && m_req0_ready) begin
                q[0].push_back('{e0, cyc}); log_id.push_back(0); log_cyc.push_back(cyc);
            end
            if (req1_valid && m_req1_ready) begin
                q[1].push_back('{e1, cyc}); log_id.push_back(1); log_cyc.push_back(cyc);
            end
            if (req0_valid && f_req0_ready) flog.push_back(0);
            if (req1_valid && f_req1_ready) flog.push_back(1);
        end
    end

    // Response side: latency on first appearance, data on every valid cycle
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (rv[i]) begin
                    if (q[i].size() == 0) begin
                        fail($sformatf("rsp%0d_unexpected result=%0h", i, rres[i]));
                    end else begin
                        if (!seen[i]) begin
                            chk($sformatf("rsp%0d_latency_cycle", i), cyc, q[i][0].cyc + 3);
                            seen[i] = 1'b1;
                        end
                        chk($sformatf("rsp%0d_result", i), rres[i], q[i][0].r.res);
                        chk($sformatf("rsp%0d_zero", i), {31'd0, rz[i]}, {31'd0, q[i][0].r.zero});
                        chk($sformatf("rsp%0d_ov", i), {31'd0, ro[i]}, {31'd0, q[i][0].r.ov});
                        if (rr[i]) begin
                            void'(q[i].pop_front());
                            seen[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send0(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input rsp_t e);
        req0_op = op; req0_a = a; req0_b = b; e0 = e; req0_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_req0_ready) begin
                @(posedge clk); #1;
                req0_valid = 1'b0;
                return;
            end
        end
        fail("req0_accept_timeout");
        req0_valid = 1'b0;
    endtask

    task automatic send1(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input rsp_t e);
        req1_op = op; req1_a = a; req1_b = b; e1 = e; req1_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_req1_ready) begin
                @(posedge clk); #1;
                req1_valid = 1'b0;
                return;
            end
        end
        fail("req1_accept_timeout");
        req1_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (q[0].size() == 0 && q[1].size() == 0 && !m_busy && rv == 2'b00) begin
                @(posedge clk); #1;
                return;
            end
        end
        fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        q[0].delete(); q[1].delete();
        seen[0] = 1'b0; seen[1] = 1'b0;
        log_id.delete(); log_cyc.delete(); flog.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic int cnt(input int id);
        int c = 0;
        foreach (log_id[k]) if (log_id[k] == id) c++;
        return c;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        // reset values, with a request presented during reset
        req0_valid = 1'b1; req0_op = ALUOP_ADD; req0_a = 32'd1; req0_b = 32'd1;
        repeat (3) @(posedge clk); #1;
        chk("reset_req0_ready", m_req0_ready, 0);
        chk("reset_busy", m_busy, 0);
        chk("reset_alu_control", m_alu_control, 0);
        chk("reset_alu_src0", m_alu_src0, 0);
        chk("reset_alu_src1", m_alu_src1, 0);
        chk("reset_rsp_valid", rv, 0);
        chk("reset_rsp0_result", m_rsp0_result, 0);
        chk("reset_last_grant", u_m.u_arb.r_last_grant, 1);
        req0_valid = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;

        // single ADD, ready in the same cycle, busy for two cycles
        req0_op = ALUOP_ADD; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        #1 chk("t1_req0_ready_same_cycle", m_req0_ready, 1);
        send0(ALUOP_ADD, 32'd5, 32'd7, mk(32'd12, 1'b0, 1'b0));
        @(negedge clk) chk("t1_busy_c1", m_busy, 1);
        @(negedge clk) chk("t1_busy_c2", m_busy, 1);
        @(negedge clk) chk("t1_busy_c3", m_busy, 0);
        drain();

        // simultaneous requests from reset: req0 first, req1 two cycles later
        do_reset();
        fork
            send0(ALUOP_ADD, 32'd1, 32'd2, mk(32'd3, 1'b0, 1'b0));
            send1(ALUOP_SUB, 32'd10, 32'd3, mk(32'd7, 1'b0, 1'b0));
        join
        drain();
        chk("t2_accept_count", log_id.size(), 2);
        if (log_id.size() >= 2) begin
            chk("t2_first_grant", log_id[0], 0);
            chk("t2_second_grant", log_id[1], 1);
            chk("t2_grant_spacing", log_cyc[1] - log_cyc[0], 2);
        end
        chk("t2_last_grant", u_m.u_arb.r_last_grant, 1);

        // overflow, zero, unknown opcode
        send0(ALUOP_ADD, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b0, 1'b1));
        send0(ALUOP_SUB, 32'd9, 32'd9, mk(32'd0, 1'b1, 1'b0));
        send1(OP_UNK, 32'd3, 32'd4, mk(32'd0, 1'b1, 1'b0));
        drain();

        // stalled rsp0 blocks the second req0 while req1 keeps flowing
        do_reset();
        rsp0_ready = 1'b0;
        fork
            begin
                send0(ALUOP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'h0F00_0F00, 1'b0, 1'b0));
                send0(ALUOP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, mk(32'h5A5A_A5A5, 1'b0, 1'b0));
            end
            begin
                send1(ALUOP_ADD, 32'd100, 32'd23, mk(32'd123, 1'b0, 1'b0));
                send1(ALUOP_OR, 32'h1000, 32'h0001, mk(32'h1001, 1'b0, 1'b0));
            end
            begin
                step(12);
                chk("t4_req0_accepts_while_stalled", cnt(0), 1);
                chk("t4_req1_accepts_while_stalled", cnt(1), 2);
                chk("t4_rsp0_held_valid", m_rsp0_valid, 1);
                rsp0_ready = 1'b1;
            end
        join
        drain();
        chk("t4_req0_accepts_total", cnt(0), 2);

        // continuous contention, starting with last_grant = req0
        do_reset();
        send0(ALUOP_ADD, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0));
        drain();
        log_id.delete(); log_cyc.delete(); flog.delete();
        req0_op = ALUOP_ADD; req0_a = 32'd2; req0_b = 32'd3; e0 = mk(32'd5, 1'b0, 1'b0);
        req1_op = ALUOP_SUB; req1_a = 32'd3; req1_b = 32'd5; e1 = mk(32'hFFFF_FFFE, 1'b0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        step(10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        chk("t5_rr_accepts", (log_id.size() >= 4) ? 1 : 0, 1);
        chk("t5_fp_accepts", (flog.size() >= 4) ? 1 : 0, 1);
        if (log_id.size() >= 4 && flog.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t5_rr_grant%0d", k), log_id[k], (k % 2 == 0) ? 1 : 0);
                chk($sformatf("t5_fp_grant%0d", k), flog[k], (k % 2 == 0) ? 0 : 1);
            end
            for (int k = 0; k < 3; k++)
                chk($sformatf("t5_rr_spacing%0d", k), log_cyc[k+1] - log_cyc[k], 2);
        end

        // reset during EXEC of a req1 op: abandoned, no response
        do_reset();
        send1(ALUOP_OR, 32'hF0, 32'h0F, mk(32'hFF, 1'b0, 1'b0));
        chk("t6_busy_before_reset", m_busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_busy", m_busy, 0);
        chk("t6_alu_control", m_alu_control, 0);
        chk("t6_alu_src0", m_alu_src0, 0);
        chk("t6_alu_src1", m_alu_src1, 0);
        chk("t6_rsp_valid", rv, 0);
        do_reset();
        step(6);
        chk("t6_no_rsp1_after_reset", m_rsp1_valid, 0);
        send0(ALUOP_AND, 32'hFF, 32'h0F, mk(32'h0F, 1'b0, 1'b0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "simulation time bound exceeded");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single registered ALU between two requesters (req0 = main pipeline, req1 = auxiliary path, e.g. exception/interrupt address math). Each requester uses a valid/ready request channel and a valid/ready response channel. The block sequences the ALU's one-cycle registered latency and captures result, Zero and Ov into a per-requester response buffer. It sits between the requesters and the ALU and is the ALU's only driver.

Parameters:
DATA_W, 32, operand/result width
OP_W, 6, ALU opcode width (ALUOP_* codes)
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, req0 wins

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
req0_op / req1_op  in  OP_W  ALUOP code
req0_a / req1_a  in  DATA_W  operand to ALU src0
req0_b / req1_b  in  DATA_W  operand to ALU src1
rsp0_valid / rsp1_valid  out  1  response buffer full
rsp0_ready / rsp1_ready  in  1  response consumed when valid&ready
rsp0_result / rsp1_result  out  DATA_W  captured ALU_result
rsp0_zero / rsp1_zero  out  1  captured Zero
rsp0_ov / rsp1_ov  out  1  captured Ov
alu_control  out  OP_W  to ALU ALU_control
alu_src0  out  DATA_W  to ALU src0
alu_src1  out  DATA_W  to ALU src1
alu_result  in  DATA_W  from ALU ALU_result
alu_zero  in  1  from ALU Zero
alu_ov  in  1  from ALU Ov
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset==0): state=IDLE; all req_ready, rsp_valid, rsp_result/zero/ov, alu_control, alu_src0/1 = 0; last_grant=1, so req0 wins first contention. An in-flight op is abandoned; no response is produced.
- FSM states: IDLE, EXEC, CAPT.
  - IDLE: accept allowed.
  - EXEC: ALU samples the op at the closing edge.
  - CAPT: alu_result, alu_zero and alu_ov are valid; alu_control/src are still held so the combinational Ov matches the op. At the closing edge the capture goes into the owner's rsp buffer. Accept is also allowed in CAPT.
  - Transitions: IDLE→EXEC on accept; EXEC→CAPT always; CAPT→EXEC on accept, else CAPT→IDLE.
- alu_control/alu_src0/alu_src1 are registers. They load from the granted request at the accept edge and hold until the next accept; there is no toggling while idle.
- Latency: accept at edge of cycle t; alu_* driven in t+1; capture at end of t+2; rsp_valid high in t+3. Peak throughput is one op per 2 cycles, back-to-back via CAPT→EXEC.
- Eligibility: elig_i = req_i_valid & ~outstanding_i.
  - outstanding_i = (in-flight op owned by i, in EXEC or CAPT) | (rsp_i_valid & ~rsp_i_ready).
  - At most one outstanding op per requester, so a capture never collides with an occupied buffer.
- Grant, only in IDLE or CAPT:
  - One eligible requester → grant it.
  - Both eligible and RR_EN=1 → grant the one != last_grant.
  - Both eligible and RR_EN=0 → grant req0.
- req_i_ready = grant_i (combinational from req valids, rsp_ready and state). Requesters must not make valid depend on ready. last_grant updates only on accept.
- Response buffer i:
  - Set on capture.
  - Cleared on rsp_i_valid & rsp_i_ready.
  - Pop and new accept by the same requester in one cycle is legal; the new result arrives 3 cycles later.
  - Data holds stable while valid & ~ready.
- Unknown opcodes are passed through unchanged; the ALU returns 0.

Decomposition:
- Shared package: FSM state encoding (IDLE/EXEC/CAPT), requester-ID width/constants, ALU latency constant (=1).
- ALUOP_* codes and ENABLE/DISABLE come from the existing define files.
- One sub-module: rr_arb2. It is a 2-way round-robin/fixed-priority arbiter: elig[1:0], accept, RR_EN → grant[1:0], last_grant register.

Test Plan:
- After reset, req0 ADD a=5 b=7, rsp0_ready=1 → req0_ready same cycle; rsp0_valid 3 cycles after accept; result=12, zero=0, ov=0; busy high for 2 cycles.
- req0 and req1 both valid in the same cycle (req0 ADD 1+2, req1 SUB 10-3) → req0 accepted first, req1 accepted 2 cycles later; rsp0=3, rsp1=7; last_grant=1.
- req0 ADD 0x7FFFFFFF+1, then SUB 9-9 → rsp0_result=0x80000000 with ov=1, then result=0 with zero=1, ov=0.
- rsp0_ready=0 with two req0 requests queued and req1 active → rsp0 holds its first result stable; second req0 is not accepted until the pop; req1 ops proceed meanwhile.
- RR_EN=1 with both requesters continuously valid and responses always ready → accepts alternate 0,1,0,1 every 2 cycles. RR_EN=0 in the same setup → req0 gets every grant while eligible.
- Assert reset in the EXEC cycle of req1 OR 0xF0|0x0F → all outputs 0 immediately, no rsp1 ever appears; the first post-reset request completes normally.
